// File: rtl/cpu_pkg.sv
// Shared processor constants and the next-PC source select used by pc_unit.
package cpu_pkg;

    localparam int unsigned PC_W_DEF      = 32;
    localparam int unsigned OFF_W_DEF     = 8;
    localparam int unsigned STRIDE_DEF    = 4;
    localparam int unsigned OFF_SHIFT_DEF = 2;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JMP,
        SEL_CALL,
        SEL_RET
    } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module ras_stack #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             push_data,
    output logic [W-1:0]             top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] DepthCnt = DEPTH[PtrW:0];

    logic [W-1:0]    mem [DEPTH];
    logic [PtrW-1:0] ptr_q;
    logic [PtrW:0]   cnt_q;
    logic            full;
    logic            empty;

    assign full      = (cnt_q == DepthCnt);
    assign empty     = (cnt_q == '0);
    assign top       = mem[ptr_q - PtrW'(1)];
    assign count     = cnt_q;
    assign overflow  = push & full;
    assign underflow = pop & empty;

    // ptr_q points at the next free slot, so it simply wraps when full.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push) begin
            mem[ptr_q] <= push_data;
            ptr_q      <= ptr_q + PtrW'(1);
            if (!full) begin
                cnt_q <= cnt_q + (PtrW + 1)'(1);
            end
        end else if (pop && !empty) begin
            ptr_q <= ptr_q - PtrW'(1);
            cnt_q <= cnt_q - (PtrW + 1)'(1);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with branch/jump/call/return select and stall hold.
// Define PC_UNIT_RAS_EN to build the return-address stack; otherwise CALL acts as JUMP.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W      = PC_W_DEF,
    parameter int unsigned OFF_W     = OFF_W_DEF,
    parameter int unsigned STRIDE    = STRIDE_DEF,
    parameter int unsigned OFF_SHIFT = OFF_SHIFT_DEF,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         STALL,
    input  logic [OFF_W-1:0]             RD_OFFSET,
    input  logic                         BRANCHEQ,
    input  logic                         BRANCHNE,
    input  logic                         ZERO,
    input  logic                         JUMP,
    input  logic                         CALL,
    input  logic                         RET,
    output logic [PC_W-1:0]              PC,
    output logic [$clog2(RAS_DEPTH):0]   RAS_COUNT,
    output logic                         RAS_OVERFLOW,
    output logic                         RAS_UNDERFLOW
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] seq;
    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] tgt;
    logic [PC_W-1:0] ret_pc;
    logic            taken_br;
    pc_sel_e         sel;

    assign seq      = pc_q + PC_W'(STRIDE);
    assign off_ext  = {{(PC_W - OFF_W){RD_OFFSET[OFF_W-1]}}, RD_OFFSET};
    assign tgt      = seq + (off_ext << OFF_SHIFT);
    assign taken_br = (BRANCHEQ & ZERO) | (BRANCHNE & ~ZERO);

    always_comb begin
        sel = SEL_SEQ;
`ifdef PC_UNIT_RAS_EN
        if (RET) begin
            sel = SEL_RET;
        end else if (CALL) begin
            sel = SEL_CALL;
        end else
`else
        if (CALL) begin
            sel = SEL_JMP;
        end else
`endif
        if (JUMP) begin
            sel = SEL_JMP;
        end else if (taken_br) begin
            sel = SEL_BR;
        end
    end

    always_comb begin
        pc_next = seq;
        unique case (sel)
            SEL_BR, SEL_JMP, SEL_CALL: pc_next = tgt;
            SEL_RET:                   pc_next = ret_pc;
            default:                   pc_next = seq;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pc_q <= '0;
        end else if (!STALL) begin
            pc_q <= pc_next;
        end
    end

    assign PC = pc_q;

`ifdef PC_UNIT_RAS_EN
    logic [PC_W-1:0]            ras_top;
    logic [$clog2(RAS_DEPTH):0] ras_count;
    logic                       ras_ovf;
    logic                       ras_udf;
    logic                       ovf_q;
    logic                       udf_q;

    // Stall gates push/pop so the stack holds along with the PC.
    ras_stack #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (CLK),
        .rst_n     (RESET),
        .push      (~STALL & (sel == SEL_CALL)),
        .pop       (~STALL & (sel == SEL_RET)),
        .push_data (seq),
        .top       (ras_top),
        .count     (ras_count),
        .overflow  (ras_ovf),
        .underflow (ras_udf)
    );

    assign ret_pc = (ras_count != '0) ? ras_top : seq;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (!STALL) begin
            ovf_q <= ovf_q | ras_ovf;
            udf_q <= udf_q | ras_udf;
        end
    end

    assign RAS_COUNT     = ras_count;
    assign RAS_OVERFLOW  = ovf_q;
    assign RAS_UNDERFLOW = udf_q;
`else
    logic ret_unused;
    assign ret_unused    = RET;
    assign ret_pc        = seq;
    assign RAS_COUNT     = '0;
    assign RAS_OVERFLOW  = 1'b0;
    assign RAS_UNDERFLOW = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed vector bench for pc_unit; expectations follow the PC_UNIT_RAS_EN build setting.
module tb_pc_unit;

    localparam logic [5:0] C_NONE = 6'b000000;
    localparam logic [5:0] C_JMP  = 6'b100000;
    localparam logic [5:0] C_CALL = 6'b010000;
    localparam logic [5:0] C_RET  = 6'b001000;
    localparam logic [5:0] C_BEQ  = 6'b000100;
    localparam logic [5:0] C_BNE  = 6'b000010;
    localparam logic [5:0] C_Z    = 6'b000001;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic [5:0]  ctl;
        logic [7:0]  off;
        logic [31:0] pc_ras;
        logic [31:0] pc_nr;
        int          cnt;
        logic        ovf;
        logic        udf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [7:0]  off = '0;
    logic        beq = 1'b0;
    logic        bne = 1'b0;
    logic        zero = 1'b0;
    logic        jmp = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] pc;
    logic [2:0]  ras_count;
    logic        ras_ovf;
    logic        ras_udf;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    pc_unit dut (
        .CLK           (clk),
        .RESET         (rst_n),
        .STALL         (stall),
        .RD_OFFSET     (off),
        .BRANCHEQ      (beq),
        .BRANCHNE      (bne),
        .ZERO          (zero),
        .JUMP          (jmp),
        .CALL          (call),
        .RET           (ret),
        .PC            (pc),
        .RAS_COUNT     (ras_count),
        .RAS_OVERFLOW  (ras_ovf),
        .RAS_UNDERFLOW (ras_udf)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic s, input logic [5:0] c,
                                input logic [7:0] o, input logic [31:0] p_ras,
                                input logic [31:0] p_nr, input int n, input logic ov,
                                input logic ud);
        vec_t v;
        v.rst_n = r; v.stall = s; v.ctl = c; v.off = o;
        v.pc_ras = p_ras; v.pc_nr = p_nr; v.cnt = n; v.ovf = ov; v.udf = ud;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int step, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic [5:0] c, input logic [7:0] o);
        rst_n = r; stall = s; off = o;
        {jmp, call, ret, beq, bne, zero} = c;
    endtask

    task automatic expect_state(input int step, input logic [31:0] p_ras, input logic [31:0] p_nr,
                                input int n, input logic ov, input logic ud);
`ifdef PC_UNIT_RAS_EN
        check("pc", step, pc, p_ras);
        check("ras_count", step, {29'd0, ras_count}, n);
        check("ras_overflow", step, {31'd0, ras_ovf}, {31'd0, ov});
        check("ras_underflow", step, {31'd0, ras_udf}, {31'd0, ud});
`else
        check("pc", step, pc, p_nr);
        check("ras_count", step, {29'd0, ras_count}, 32'd0);
        check("ras_overflow", step, {31'd0, ras_ovf}, 32'd0);
        check("ras_underflow", step, {31'd0, ras_udf}, 32'd0);
`endif
    endtask

    task automatic step_cycle(input int step, input logic r, input logic s, input logic [5:0] c,
                              input logic [7:0] o, input logic [31:0] p_ras,
                              input logic [31:0] p_nr, input int n, input logic ov,
                              input logic ud);
        drive(r, s, c, o);
        @(posedge clk);
        #1;
        expect_state(step, p_ras, p_nr, n, ov, ud);
    endtask

    initial begin
        // rst stall ctl off  pc(ras) pc(no ras) cnt ovf udf
        add(0, 0, C_NONE,       8'h00, 32'd0,  32'd0,  0, 0, 0);
        add(1, 0, C_NONE,       8'h00, 32'd4,  32'd4,  0, 0, 0);
        add(1, 0, C_NONE,       8'h00, 32'd8,  32'd8,  0, 0, 0);
        add(1, 0, C_NONE,       8'h00, 32'd12, 32'd12, 0, 0, 0);
        add(1, 0, C_JMP,        8'hFE, 32'd8,  32'd8,  0, 0, 0);
        add(1, 0, C_BEQ | C_Z,  8'hFD, 32'd0,  32'd0,  0, 0, 0);
        add(1, 0, C_NONE,       8'h00, 32'd4,  32'd4,  0, 0, 0);
        add(1, 0, C_NONE,       8'h00, 32'd8,  32'd8,  0, 0, 0);
        add(1, 0, C_BEQ,        8'hFD, 32'd12, 32'd12, 0, 0, 0);
        add(1, 0, C_JMP,        8'hFE, 32'd8,  32'd8,  0, 0, 0);
        add(1, 0, C_BNE,        8'hFD, 32'd0,  32'd0,  0, 0, 0);
        add(1, 0, C_NONE,       8'h00, 32'd4,  32'd4,  0, 0, 0);
        add(1, 0, C_NONE,       8'h00, 32'd8,  32'd8,  0, 0, 0);
        add(1, 0, C_BNE | C_Z,  8'hFD, 32'd12, 32'd12, 0, 0, 0);
        add(1, 0, C_NONE,       8'h00, 32'd16, 32'd16, 0, 0, 0);
        add(1, 0, C_CALL,       8'h05, 32'd40, 32'd40, 1, 0, 0);
        add(1, 0, C_RET,        8'h00, 32'd20, 32'd44, 0, 0, 0);
        add(0, 0, C_NONE,       8'h00, 32'd0,  32'd0,  0, 0, 0);
        add(1, 0, C_CALL,       8'h00, 32'd4,  32'd4,  1, 0, 0);
        add(1, 0, C_CALL,       8'h00, 32'd8,  32'd8,  2, 0, 0);
        add(1, 0, C_CALL,       8'h00, 32'd12, 32'd12, 3, 0, 0);
        add(1, 0, C_CALL,       8'h00, 32'd16, 32'd16, 4, 0, 0);
        add(1, 0, C_CALL,       8'h00, 32'd20, 32'd20, 4, 1, 0);
        add(1, 0, C_RET,        8'h00, 32'd20, 32'd24, 3, 1, 0);
        add(1, 0, C_RET,        8'h00, 32'd16, 32'd28, 2, 1, 0);
        add(1, 0, C_RET,        8'h00, 32'd12, 32'd32, 1, 1, 0);
        add(1, 0, C_RET,        8'h00, 32'd8,  32'd36, 0, 1, 0);
        add(1, 0, C_RET,        8'h00, 32'd12, 32'd40, 0, 1, 1);
        add(1, 0, C_CALL,       8'h00, 32'd16, 32'd44, 1, 1, 1);
        add(1, 1, C_JMP,        8'h05, 32'd16, 32'd44, 1, 1, 1);
        add(1, 1, C_JMP,        8'h05, 32'd16, 32'd44, 1, 1, 1);
        add(1, 1, C_JMP,        8'h05, 32'd16, 32'd44, 1, 1, 1);
        add(0, 1, C_JMP,        8'h05, 32'd0,  32'd0,  0, 0, 0);
        add(1, 0, C_NONE,       8'h00, 32'd4,  32'd4,  0, 0, 0);
        add(1, 0, C_JMP,        8'hFD, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 0, 0);
        add(1, 0, C_NONE,       8'h00, 32'd0,  32'd0,  0, 0, 0);
        add(1, 0, C_CALL,       8'h00, 32'd4,  32'd4,  1, 0, 0);
        add(1, 0, C_CALL,       8'h00, 32'd8,  32'd8,  2, 0, 0);
        add(1, 0, C_CALL|C_RET, 8'h05, 32'd8,  32'd32, 1, 0, 0);
        add(1, 0, C_RET,        8'h00, 32'd4,  32'd36, 0, 0, 0);
        add(1, 0, C_RET,        8'h00, 32'd8,  32'd40, 0, 0, 1);

        drive(0, 0, C_NONE, 8'h00);
        for (int i = 0; i < vecs.size(); i++) begin
            step_cycle(i, vecs[i].rst_n, vecs[i].stall, vecs[i].ctl, vecs[i].off,
                       vecs[i].pc_ras, vecs[i].pc_nr, vecs[i].cnt, vecs[i].ovf, vecs[i].udf);
        end

        // Reset mid call chain must drop the stacked returns.
        step_cycle(100, 0, 0, C_NONE, 8'h00, 32'd0,  32'd0,  0, 0, 0);
        step_cycle(101, 1, 0, C_CALL, 8'h02, 32'd12, 32'd12, 1, 0, 0);
        step_cycle(102, 1, 0, C_CALL, 8'h02, 32'd24, 32'd24, 2, 0, 0);
        step_cycle(103, 0, 0, C_CALL, 8'h02, 32'd0,  32'd0,  0, 0, 0);
        step_cycle(104, 1, 0, C_RET,  8'h00, 32'd4,  32'd4,  0, 0, 1);

        // Stall with a taken branch, then release: the branch applies on the first free edge.
        step_cycle(105, 1, 1, C_BEQ | C_Z, 8'h01, 32'd4,  32'd4,  0, 0, 1);
        step_cycle(106, 1, 0, C_BEQ | C_Z, 8'h01, 32'd12, 32'd12, 0, 0, 1);
        step_cycle(107, 1, 0, C_NONE,      8'h00, 32'd16, 32'd16, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
